// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter for IF/MEM pipeline stages
//
// Shares one single-ported instruction/data memory between the fetch stage and
// the load/store stage. Each pipeline step may need up to two memory accesses.
// The data access is issued first and the fetch second, and the whole pipeline
// is frozen until both have been acknowledged.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   if_req/if_addr  fetch request and PC for this pipeline step
//   if_instr        last fetched instruction (registered)
//   dm_read/dm_write/dm_addr/dm_wdata  load/store request from MEM stage
//   dm_rdata        last loaded data word (registered)
//   mem_req/mem_we/mem_addr/mem_wdata  registered request to the memory
//   mem_rdata/mem_ack                  memory response, any latency >= 1
//   stall_pipe      combinational freeze of every pipeline register

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_instr,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_pipe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic if_done;
  logic dm_done;

  logic need_dm;
  logic dm_pend;
  logic if_pend;
  logic advance;

  logic          req_nxt;
  logic          we_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          cap_if;
  logic          cap_dm;
  logic          set_if_done;
  logic          set_dm_done;

  assign need_dm = dm_read | dm_write;
  assign dm_pend = need_dm & ~dm_done;
  assign if_pend = if_req & ~if_done;

  // The pipeline advances only once every access of this step has completed.
  // A capture edge always has its own access still pending, so advance and
  // capture never fall on the same edge.
  assign advance    = ~(dm_pend | if_pend);
  assign stall_pipe = ~rst & ~advance;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: data first, since it belongs to the older instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_pend) begin
          state_nxt = DATA;
        end else if (if_pend) begin
          state_nxt = INST;
        end
      end
      DATA: begin
        if (mem_ack) begin
          state_nxt = if_pend ? INST : IDLE;
        end
      end
      INST: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered memory interface plus
  // capture/done strobes. Every mem_* output holds while waiting for ack.
  always_comb begin
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    cap_if      = 1'b0;
    cap_dm      = 1'b0;
    set_if_done = 1'b0;
    set_dm_done = 1'b0;
    case (state)
      IDLE: begin
        // mem_ack is ignored here: nothing is outstanding.
        if (dm_pend) begin
          req_nxt   = 1'b1;
          we_nxt    = dm_write;
          addr_nxt  = dm_addr;
          wdata_nxt = dm_wdata;
        end else if (if_pend) begin
          req_nxt  = 1'b1;
          we_nxt   = 1'b0;
          addr_nxt = if_addr;
        end
      end
      DATA: begin
        if (mem_ack) begin
          set_dm_done = 1'b1;
          // Read+write together is a store; only a pure load captures.
          cap_dm = dm_read & ~dm_write;
          we_nxt = 1'b0;
          if (if_pend) begin
            // Chain straight into the fetch without dropping mem_req.
            req_nxt  = 1'b1;
            addr_nxt = if_addr;
          end else begin
            req_nxt = 1'b0;
          end
        end
      end
      INST: begin
        if (mem_ack) begin
          cap_if      = 1'b1;
          set_if_done = 1'b1;
          req_nxt     = 1'b0;
        end
      end
      default: begin
        req_nxt = 1'b0;
        we_nxt  = 1'b0;
      end
    endcase
  end

  // Registered memory interface, result registers and done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_instr  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if (cap_if) begin
        if_instr <= mem_rdata;
      end
      if (cap_dm) begin
        dm_rdata <= mem_rdata;
      end
      if (advance) begin
        if_done <= 1'b0;
        dm_done <= 1'b0;
      end else begin
        if (set_if_done) begin
          if_done <= 1'b1;
        end
        if (set_dm_done) begin
          dm_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_instr;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_pipe;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_instr   (if_instr),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_pipe (stall_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        rd;
    logic        wr;
    logic [31:0] da;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rdat;
    logic [1:0]  push;     // bit1: expect data transfer, bit0: expect fetch
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  vec_t  tbl[$];
  xfer_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic vec_t v(
    input logic ifr, input logic [31:0] ia,
    input logic rd, input logic wr, input logic [31:0] da, input logic [31:0] wd,
    input logic ack, input logic [31:0] rdat, input logic [1:0] push,
    input logic e_stall, input logic e_req, input logic e_we, input logic [31:0] e_addr,
    input logic [31:0] e_instr, input logic [31:0] e_rdata);
    vec_t r;
    r.ifr = ifr; r.ia = ia; r.rd = rd; r.wr = wr; r.da = da; r.wd = wd;
    r.ack = ack; r.rdat = rdat; r.push = push;
    r.e_stall = e_stall; r.e_req = e_req; r.e_we = e_we; r.e_addr = e_addr;
    r.e_instr = e_instr; r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    x.we = we; x.addr = addr; x.wdata = wdata;
    sb.push_back(x);
  endtask

  // Scoreboard: every acknowledged transfer must match the next expected one.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: transfer addr %h we %b with nothing expected", mem_addr, mem_we);
      end else begin
        xfer_t x;
        x = sb.pop_front();
        chk("sb_we", {31'd0, mem_we}, {31'd0, x.we});
        chk("sb_addr", mem_addr, x.addr);
        if (x.we) chk("sb_wdata", mem_wdata, x.wdata);
      end
    end
  end

  task automatic drive(input vec_t r);
    if_req = r.ifr; if_addr = r.ia;
    dm_read = r.rd; dm_write = r.wr; dm_addr = r.da; dm_wdata = r.wd;
    mem_ack = r.ack; mem_rdata = r.rdat;
    if (r.push[1]) push_xfer(r.wr, r.da, r.wd);
    if (r.push[0]) push_xfer(1'b0, r.ia, 32'd0);
  endtask

  task automatic check_vec(input string tag, input vec_t r);
    chk({tag, " stall"}, {31'd0, stall_pipe}, {31'd0, r.e_stall});
    chk({tag, " mem_req"}, {31'd0, mem_req}, {31'd0, r.e_req});
    chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, r.e_we});
    chk({tag, " mem_addr"}, mem_addr, r.e_addr);
    chk({tag, " if_instr"}, if_instr, r.e_instr);
    chk({tag, " dm_rdata"}, dm_rdata, r.e_rdata);
  endtask

  task automatic run_row(input string tag, input vec_t r);
    @(posedge clk);
    #1;
    drive(r);
    @(negedge clk);
    check_vec(tag, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    // Reset with requests and ack active: everything must stay quiet.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h5;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("reset%0d stall", c), {31'd0, stall_pipe}, 32'd0);
      chk($sformatf("reset%0d mem_req", c), {31'd0, mem_req}, 32'd0);
      chk($sformatf("reset%0d mem_we", c), {31'd0, mem_we}, 32'd0);
      chk($sformatf("reset%0d mem_addr", c), mem_addr, 32'd0);
      chk($sformatf("reset%0d mem_wdata", c), mem_wdata, 32'd0);
      chk($sformatf("reset%0d if_instr", c), if_instr, 32'd0);
      chk($sformatf("reset%0d dm_rdata", c), dm_rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    if_req = 1'b0; dm_read = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;

    //              ifr ia     rd wr da      wd            ack rdat          push st rq we addr     instr         rdata
    // Fetch only, 1-cycle ack
    tbl.push_back(v(1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b01, 1, 0, 0, 32'h0,   32'h0,        32'h0));
    tbl.push_back(v(1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 32'h20020005,  2'b00, 1, 1, 0, 32'h40,  32'h0,        32'h0));
    tbl.push_back(v(1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h40,  32'h20020005, 32'h0));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h40,  32'h20020005, 32'h0));
    // Load plus fetch, 1-cycle acks, mem_req continuous
    tbl.push_back(v(1, 32'h44, 1, 0, 32'h100, 32'h0,        0, 32'h0,         2'b11, 1, 0, 0, 32'h40,  32'h20020005, 32'h0));
    tbl.push_back(v(1, 32'h44, 1, 0, 32'h100, 32'h0,        1, 32'hDEADBEEF,  2'b00, 1, 1, 0, 32'h100, 32'h20020005, 32'h0));
    tbl.push_back(v(1, 32'h44, 1, 0, 32'h100, 32'h0,        1, 32'h8C220004,  2'b00, 1, 1, 0, 32'h44,  32'h20020005, 32'hDEADBEEF));
    tbl.push_back(v(1, 32'h44, 1, 0, 32'h100, 32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h44,  32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h44,  32'h8C220004, 32'hDEADBEEF));
    // Store, ack on the third request cycle; rdata on the bus must not be captured
    tbl.push_back(v(0, 32'h0,  0, 1, 32'h200, 32'h12345678, 0, 32'h0,         2'b10, 1, 0, 0, 32'h44,  32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'h200, 32'h12345678, 0, 32'h0,         2'b00, 1, 1, 1, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'h200, 32'h12345678, 0, 32'h0,         2'b00, 1, 1, 1, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'h200, 32'h12345678, 1, 32'hFFFFFFFF,  2'b00, 1, 1, 1, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'h200, 32'h12345678, 0, 32'h0,         2'b00, 0, 0, 0, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    // Spurious ack in IDLE
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'hAAAAAAAA,  2'b00, 0, 0, 0, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    // Read and write together is a store only
    tbl.push_back(v(0, 32'h0,  1, 1, 32'h300, 32'h55,       0, 32'h0,         2'b10, 1, 0, 0, 32'h200, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  1, 1, 32'h300, 32'h55,       1, 32'h77,        2'b00, 1, 1, 1, 32'h300, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  1, 1, 32'h300, 32'h55,       0, 32'h0,         2'b00, 0, 0, 0, 32'h300, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h300, 32'h8C220004, 32'hDEADBEEF));
    // Fetch with one extra wait cycle
    tbl.push_back(v(1, 32'h48, 0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b01, 1, 0, 0, 32'h300, 32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(1, 32'h48, 0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 1, 1, 0, 32'h48,  32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(1, 32'h48, 0, 0, 32'h0,   32'h0,        1, 32'h1234,      2'b00, 1, 1, 0, 32'h48,  32'h8C220004, 32'hDEADBEEF));
    tbl.push_back(v(1, 32'h48, 0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h48,  32'h1234,     32'hDEADBEEF));
    tbl.push_back(v(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,         2'b00, 0, 0, 0, 32'h48,  32'h1234,     32'hDEADBEEF));

    for (int i = 0; i < tbl.size(); i++) begin
      run_row($sformatf("row%0d", i), tbl[i]);
    end

    // Reset while a data access is outstanding: mem_req must drop at once.
    run_row("mid0", v(1, 32'h4C, 1, 0, 32'h400, 32'h0, 0, 32'h0, 2'b00, 1, 0, 0, 32'h48,  32'h1234, 32'hDEADBEEF));
    run_row("mid1", v(1, 32'h4C, 1, 0, 32'h400, 32'h0, 0, 32'h0, 2'b00, 1, 1, 0, 32'h400, 32'h1234, 32'hDEADBEEF));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst stall", {31'd0, stall_pipe}, 32'd0);
    chk("mid_rst if_instr", if_instr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_xfer(1'b0, 32'h400, 32'h0);
    push_xfer(1'b0, 32'h4C, 32'h0);
    @(negedge clk);
    chk("restart stall", {31'd0, stall_pipe}, 32'd1);
    chk("restart mem_req", {31'd0, mem_req}, 32'd0);
    run_row("restart1", v(1, 32'h4C, 1, 0, 32'h400, 32'h0, 1, 32'hCAFE0001, 2'b00, 1, 1, 0, 32'h400, 32'h0,        32'h0));
    run_row("restart2", v(1, 32'h4C, 1, 0, 32'h400, 32'h0, 1, 32'hCAFE0002, 2'b00, 1, 1, 0, 32'h4C,  32'h0,        32'hCAFE0001));
    run_row("restart3", v(1, 32'h4C, 1, 0, 32'h400, 32'h0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h4C,  32'hCAFE0002, 32'hCAFE0001));
    r = v(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h4C, 32'hCAFE0002, 32'hCAFE0001);
    run_row("restart4", r);

    chk("sb_left", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
- Sequences the accesses requested for one pipeline step.
- Drives a global stall that freezes all pipeline registers, including the EX/MEM register, until every access for that step has completed.
- Accepts any memory acknowledge latency of 1 cycle or more.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  instruction fetch wanted this pipeline step
if_addr  in  AW  fetch address (PC)
if_instr  out  DW  fetched instruction, registered
dm_read  in  1  load requested by the MEM stage
dm_write  in  1  store requested by the MEM stage
dm_addr  in  AW  load/store address (ALU result)
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data, registered
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data, valid when mem_ack=1
mem_ack  in  1  transfer complete; sampled at the rising edge while mem_req=1
stall_pipe  out  1  freeze all pipeline registers (combinational)

Behaviour:
- Reset, asynchronous:
  - state=IDLE; if_done=0, dm_done=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_instr=0, dm_rdata=0.
  - mem_req drops immediately when rst rises, not at the next edge.
- Derived signals:
  - need_dm = dm_read | dm_write.
  - dm_write=dm_read=1 is treated as a write only.
- stall_pipe = (need_dm & ~dm_done) | (if_req & ~if_done).
  - Combinational; 0 during reset.
  - 0 when there are no requests.
- Stability: inputs are guaranteed stable while stall_pipe=1, because the pipeline is frozen.
- States: IDLE, DATA, INST.
- IDLE:
  - If need_dm & ~dm_done: go to DATA.
    - mem_req<=1; mem_we<=dm_write; mem_addr<=dm_addr; mem_wdata<=dm_wdata.
  - Else if if_req & ~if_done: go to INST.
    - mem_req<=1; mem_we<=0; mem_addr<=if_addr.
  - Else stay in IDLE.
  - Priority: data over fetch, because the data access belongs to the older instruction.
- DATA:
  - Hold every mem_* output until an edge with mem_ack=1.
  - At that edge: dm_done<=1; if dm_read & ~dm_write, dm_rdata<=mem_rdata.
  - Then, if if_req & ~if_done: go directly to INST (mem_req stays 1, mem_we<=0, mem_addr<=if_addr).
  - Otherwise go to IDLE with mem_req<=0, mem_we<=0.
- INST:
  - Hold every mem_* output until an edge with mem_ack=1.
  - At that edge: if_instr<=mem_rdata; if_done<=1; mem_req<=0; go to IDLE.
- Done flags:
  - On any edge where stall_pipe=0 (the pipeline advances), if_done<=0 and dm_done<=0.
  - This edge never coincides with a capture.
- mem_ack handling: ignored in IDLE; no capture and no state change.
- if_instr and dm_rdata hold their value until the next capture. A store does not change dm_rdata.
- Latency with mem_ack at its earliest cycle:
  - Fetch only: stall_pipe high for 2 cycles.
  - Load/store plus fetch: stall_pipe high for 3 cycles.
  - Each extra memory wait cycle adds one stall cycle.

Test Plan:
- Reset: hold rst for 2 cycles with mem_ack=1 and requests active → every output 0, stall_pipe=0, mem_req=0 throughout.
- Fetch only, 1-cycle ack:
  - Stimulus: if_req=1, if_addr=0x40; mem_ack=1 with mem_rdata=0x20020005 in cycle 1.
  - Cycles 0-1: stall_pipe=1; mem_req=1, mem_addr=0x40, mem_we=0 in cycle 1.
  - Cycle 2: stall_pipe=0, if_instr=0x20020005, mem_req=0.
- Load plus fetch, 1-cycle acks:
  - Stimulus: dm_read=1, dm_addr=0x100, rdata 0xDEADBEEF; if_addr=0x44, rdata 0x8C220004.
  - mem_addr sequence: 0x100 then 0x44, with mem_req continuously 1.
  - stall_pipe=1 for cycles 0-2 and 0 in cycle 3.
  - Result: dm_rdata=0xDEADBEEF, if_instr=0x8C220004.
- Store, ack after 3 cycles:
  - Stimulus: dm_write=1, dm_addr=0x200, dm_wdata=0x12345678; if_req=0.
  - mem_we=1, mem_addr=0x200, mem_wdata=0x12345678, all stable for 3 cycles.
  - stall_pipe drops the cycle after ack; dm_rdata is unchanged.
- Reset mid-operation: assert rst while in DATA with ack pending → mem_req=0 immediately. After release with the same requests, the sequence restarts from IDLE with the data access first.
- Spurious ack: mem_ack=1 in IDLE with no requests → no capture, state stays IDLE, stall_pipe=0, if_instr and dm_rdata unchanged.
